lcd_cmd_arbiter: RTL and testbench
==================================

# lcd_cmd_arbiter

Round-robin arbiter that shares the LCD printer's 32-bit command FIFO write port between `N_REQ` draw requesters (tank sprites, map tiles, HUD, boot/init). Each granted request is written atomically as either one init word (32'hFFFF_FFFF) or a three-word draw command in the order XY, Size, Addr. No other requester's words are ever interleaved. Sits between the game-logic/AHB-side requesters and the write side of the printer command FIFO.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  N_REQ: per-requester request; held high until `req_ack`.
- `req_init`  in  N_REQ: 1 = init command, 0 = draw command; sampled at grant.
- `req_xy`  in  32·N_REQ: XY word {XH,XL,YH,YL} per requester; slice i = bits [32i+31:32i].
- `req_size`  in  32·N_REQ: Size word; the printer uses only [4:0].
- `req_addr`  in  32·N_REQ: pixel base byte address, halfword aligned.
- `req_ack`  out  N_REQ: one-cycle completion pulse to the granted requester.
- `req_err`  out  N_REQ: qualifies `req_ack`; 1 = request rejected, nothing written.
- `cmd_wfull`  in  1: command FIFO full.
- `cmd_winc`  out  1: command FIFO write strobe.
- `cmd_wdata`  out  32: command FIFO write data.
- `busy`  out  1: a command is in progress (state ≠ IDLE).

## Operation
- States: IDLE, W_XY, W_SIZE, W_ADDR, W_INIT.
- IDLE: if any `req_valid` is set, grant the first set bit searching from `last+1` upward modulo N_REQ. Latch the grant index and that requester's xy/size/addr/init into holding registers. Update `last` to the grant index.
- Next state from IDLE:
  - to W_INIT if the latched init flag is 1;
  - else to W_XY if xy ≠ 32'hFFFF_FFFF;
  - else reject: pulse `req_ack` and `req_err` for the granted requester in the following cycle and stay in IDLE. All-ones XY would be decoded as init by the printer, so it is never written.
- W_INIT: write INIT_WORD, then go to IDLE.
- Draw sequence: W_XY writes latched xy → W_SIZE writes latched size → W_ADDR writes latched addr → IDLE.
- Write rule in every W_* state: `cmd_winc` = !`cmd_wfull` (combinational); `cmd_wdata` = the word for the current state. The state advances only on a cycle where `cmd_winc` = 1. While full, the state is held and `cmd_winc` = 0.
- `req_ack[grant]` = `cmd_winc` in W_ADDR or W_INIT, i.e. in the same cycle as the last word's write; `req_err` = 0 in this case.
- The requester's payload may change after the grant edge, because the held copy is used. `req_valid` must drop on the edge after `req_ack`. A still-high `req_valid` at that point is treated as a new request.
- `req_valid` changes during a command are ignored until IDLE.
- A requester dropping `req_valid` mid-command does not abort the command.

## Timing
- Reset values: state IDLE, `last` = N_REQ-1 (requester 0 wins first), `cmd_winc` 0, `cmd_wdata` 0, `req_ack` 0, `req_err` 0, `busy` 0, holding registers 0.
- Reset mid-command: abandon immediately. Any words already written remain in the FIFO; no ack is issued.
- Latency with the FIFO not full: valid in IDLE at cycle 0 → XY written in cycle 1, Size in 2, Addr plus ack in 3, IDLE in 4. Init: written plus ack in cycle 1, IDLE in 2.
- Throughput: one draw per 4 cycles, one init per 2 cycles.
- `cmd_wdata` is 0 in IDLE. Outside W_* states, `cmd_winc` is never 1.
- `busy` = registered state ≠ IDLE.

## Structure
- Package `lcd_cmd_pkg`:
  - INIT_WORD = 32'hFFFF_FFFF;
  - state encoding (5 states, 3 bits);
  - word order constants shared with the printer side.
- Sub-module `rr_arbiter`:
  - inputs: `req` vector and `last` pointer;
  - outputs: one-hot grant, grant index, `any`;
  - combinational;
  - the `last` register lives in the parent.

## Test plan
- Single draw: req 0 with xy=32'h0010_0020, size=32'h0F, addr=32'h2000_0100, FIFO empty → FIFO words in order 0010_0020, 0000_000F, 2000_0100 in cycles 1–3; `req_ack[0]` in cycle 3 only.
- Round robin: all 4 requesters valid with distinct init/draw mixes, each dropping valid after its ack → grant order 0,1,2,3, then 0 again if re-raised; words never interleaved.
- Backpressure: assert `cmd_wfull` for 5 cycles while in W_SIZE → no `cmd_winc`, state held, Size written in the first non-full cycle, Addr after it; total 3 writes.
- Illegal XY: req 2 draw with xy=32'hFFFF_FFFF → zero FIFO writes, `req_ack[2]` and `req_err[2]` pulse together one cycle after the grant.
- Init request: req 3 `req_init`=1 → single write 32'hFFFF_FFFF, ack in the same cycle, `busy` high for exactly 1 cycle.
- Reset mid-draw: `rst_n` low in W_SIZE → next cycle IDLE, `cmd_winc` 0, no ack; after release, req 0 is granted first.

Source files
------------

// File: rtl/lcd_cmd_pkg.sv
// lcd_cmd_pkg
// Shared definitions for the LCD printer command path: the init word, the
// arbiter FSM encoding and the order in which draw-command words are
// written to the printer command FIFO (XY, then Size, then Addr).
package lcd_cmd_pkg;

    // The printer decodes an all-ones word as an init command.
    localparam logic [31:0] INIT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_XY   = 3'd1,
        ST_W_SIZE = 3'd2,
        ST_W_ADDR = 3'd3,
        ST_W_INIT = 3'd4
    } state_t;

    // Every non-idle state owns exactly one FIFO word.
    function automatic logic is_write_state(input state_t s);
        return s != ST_IDLE;
    endfunction

    // Word order shared with the printer: XY -> Size -> Addr; init is a
    // single word. Taken only after the current word has been written.
    function automatic state_t next_write_state(input state_t s);
        case (s)
            ST_W_XY:   return ST_W_SIZE;
            ST_W_SIZE: return ST_W_ADDR;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: grants the first set bit of req searching
// upward from last+1, wrapping modulo N_REQ. The last pointer is owned by
// the parent.
// Ports:
//   req     in  N_REQ  request vector
//   last    in  IDX_W  index granted most recently
//   gnt     out N_REQ  one-hot grant
//   gnt_idx out IDX_W  index of the granted bit (0 when none)
//   any     out 1      at least one request is set
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        // k = N_REQ wraps back to last itself, so a lone requester that
        // was just served can still be granted again.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % N_REQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter
// Shares the printer command FIFO write port between N_REQ requesters.
// A granted request is written atomically: one init word, or the three
// draw words XY, Size, Addr, with no other requester's words in between.
// Handshake: a requester holds req_valid until it sees req_ack (one-cycle
// pulse, qualified by req_err) and drops it on the following edge; the
// payload is copied at grant so it may change afterwards.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_init   per-requester request and init flag
//   req_xy/size/addr     per-requester payload, 32 bits per slice
//   req_ack/req_err      completion pulse and reject qualifier
//   cmd_wfull            FIFO full
//   cmd_winc/cmd_wdata   FIFO write strobe and data
//   busy                 a command is in progress
module lcd_cmd_arbiter
    import lcd_cmd_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_init,
    input  logic [32*N_REQ-1:0]   req_xy,
    input  logic [32*N_REQ-1:0]   req_size,
    input  logic [32*N_REQ-1:0]   req_addr,
    output logic [N_REQ-1:0]      req_ack,
    output logic [N_REQ-1:0]      req_err,
    input  logic                  cmd_wfull,
    output logic                  cmd_winc,
    output logic [31:0]           cmd_wdata,
    output logic                  busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [31:0]      xy_q, xy_d;
    logic [31:0]      size_q, size_d;
    logic [31:0]      addr_q, addr_d;
    logic             init_q, init_d;
    logic             rej_q, rej_d;

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    logic [31:0]      sel_xy, sel_size, sel_addr;
    logic             sel_init;

    // While a reject is being acknowledged the requester's valid is still
    // high; masking it stops the same request being granted twice.
    assign arb_req = rej_q ? '0 : req_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (arb_req),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // AND-OR payload select from the one-hot grant.
    always_comb begin
        sel_xy   = '0;
        sel_size = '0;
        sel_addr = '0;
        sel_init = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_xy   = sel_xy   | req_xy[32*i +: 32];
                sel_size = sel_size | req_size[32*i +: 32];
                sel_addr = sel_addr | req_addr[32*i +: 32];
                sel_init = sel_init | req_init[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_idx_d = gnt_idx_q;
        xy_d      = xy_q;
        size_d    = size_q;
        addr_d    = addr_q;
        init_d    = init_q;
        rej_d     = 1'b0;
        cmd_winc  = 1'b0;
        cmd_wdata = '0;
        req_ack   = '0;
        req_err   = '0;

        if (rej_q) begin
            req_ack[gnt_idx_q] = 1'b1;
            req_err[gnt_idx_q] = 1'b1;
        end

        if (is_write_state(state_q)) begin
            cmd_winc = !cmd_wfull;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    last_d    = arb_idx;
                    gnt_idx_d = arb_idx;
                    xy_d      = sel_xy;
                    size_d    = sel_size;
                    addr_d    = sel_addr;
                    init_d    = sel_init;
                    if (sel_init) begin
                        state_d = ST_W_INIT;
                    end else if (sel_xy != INIT_WORD) begin
                        state_d = ST_W_XY;
                    end else begin
                        // All-ones XY would read as init at the printer.
                        rej_d = 1'b1;
                    end
                end
            end
            ST_W_XY:   cmd_wdata = xy_q;
            ST_W_SIZE: cmd_wdata = size_q;
            ST_W_ADDR: cmd_wdata = addr_q;
            ST_W_INIT: cmd_wdata = INIT_WORD;
            default:   cmd_wdata = '0;
        endcase

        if (cmd_winc) begin
            state_d = next_write_state(state_q);
            if (state_q == ST_W_ADDR || state_q == ST_W_INIT) begin
                req_ack[gnt_idx_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= IDX_W'(N_REQ - 1);
            gnt_idx_q <= '0;
            xy_q      <= '0;
            size_q    <= '0;
            addr_q    <= '0;
            init_q    <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_idx_q <= gnt_idx_d;
            xy_q      <= xy_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            init_q    <= init_d;
            rej_q     <= rej_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
module tb_lcd_cmd_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_init;
    logic [32*N-1:0] req_xy;
    logic [32*N-1:0] req_size;
    logic [32*N-1:0] req_addr;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    req_err;
    logic            cmd_wfull;
    logic            cmd_winc;
    logic [31:0]     cmd_wdata;
    logic            busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // observed per-cycle outputs
    logic            s_winc;
    logic [31:0]     s_wdata;
    logic [N-1:0]    s_ack;
    logic [N-1:0]    s_err;
    logic            s_busy;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  ack_log[$];
    logic [7:0]  exp_ack[$];

    lcd_cmd_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_init  (req_init),
        .req_xy    (req_xy),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .cmd_wfull (cmd_wfull),
        .cmd_winc  (cmd_winc),
        .cmd_wdata (cmd_wdata),
        .busy      (busy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_streams(input string tag);
        check({tag, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s word %0d", tag, i), got_q[i], exp_q[i]);
        check({tag, " ack count"}, 32'(ack_log.size()), 32'(exp_ack.size()));
        for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++)
            check($sformatf("%s ack %0d", tag, i), 32'(ack_log[i]), 32'(exp_ack[i]));
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: sample outputs at the falling edge, log writes and
    // acks, then after the rising edge drop valid for acked requesters.
    task automatic clk_cycle();
        @(negedge clk);
        s_winc  = cmd_winc;
        s_wdata = cmd_wdata;
        s_ack   = req_ack;
        s_err   = req_err;
        s_busy  = busy;
        if (s_winc) got_q.push_back(s_wdata);
        if (|s_ack) ack_log.push_back({s_err, s_ack});
        @(posedge clk);
        #1;
        req_valid = req_valid & ~s_ack;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        ack_log.delete();
        exp_ack.delete();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        cmd_wfull = 1'b0;
        run(2);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic set_req(input int i, input logic init, input logic [31:0] xy,
                           input logic [31:0] size, input logic [31:0] addr);
        req_init[i]          = init;
        req_xy[32*i +: 32]   = xy;
        req_size[32*i +: 32] = size;
        req_addr[32*i +: 32] = addr;
        req_valid[i]         = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_init  = '0;
        req_xy    = '0;
        req_size  = '0;
        req_addr  = '0;
        cmd_wfull = 1'b0;

        // reset state
        do_reset();
        clk_cycle();
        check("reset busy",  32'(s_busy), 32'd0);
        check("reset winc",  32'(s_winc), 32'd0);
        check("reset wdata", s_wdata,     32'd0);
        check("reset ack",   32'(s_ack),  32'd0);
        check("reset err",   32'(s_err),  32'd0);

        // single draw, payload changed after grant
        set_req(0, 1'b0, 32'h0010_0020, 32'h0000_000F, 32'h2000_0100);
        clk_cycle();
        check("draw c0 winc", 32'(s_winc), 32'd0);
        check("draw c0 busy", 32'(s_busy), 32'd0);
        req_xy[31:0]   = 32'hDEAD_BEEF;
        req_size[31:0] = 32'h0000_0001;
        req_addr[31:0] = 32'h0BAD_0000;
        clk_cycle();
        check("draw c1 winc",  32'(s_winc), 32'd1);
        check("draw c1 wdata", s_wdata,     32'h0010_0020);
        check("draw c1 ack",   32'(s_ack),  32'd0);
        check("draw c1 busy",  32'(s_busy), 32'd1);
        clk_cycle();
        check("draw c2 winc",  32'(s_winc), 32'd1);
        check("draw c2 wdata", s_wdata,     32'h0000_000F);
        check("draw c2 ack",   32'(s_ack),  32'd0);
        clk_cycle();
        check("draw c3 winc",  32'(s_winc), 32'd1);
        check("draw c3 wdata", s_wdata,     32'h2000_0100);
        check("draw c3 ack",   32'(s_ack),  32'b0001);
        check("draw c3 err",   32'(s_err),  32'd0);
        clk_cycle();
        check("draw c4 busy",  32'(s_busy), 32'd0);
        check("draw c4 winc",  32'(s_winc), 32'd0);
        check("draw c4 wdata", s_wdata,     32'd0);
        check("draw c4 ack",   32'(s_ack),  32'd0);

        // round robin with init/draw mix
        do_reset();
        set_req(0, 1'b0, 32'h00A0_00A0, 32'h0000_0001, 32'h0000_0100);
        set_req(1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        set_req(2, 1'b0, 32'h00B0_00B0, 32'h0000_0002, 32'h0000_0200);
        set_req(3, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
        exp_q = '{32'h00A0_00A0, 32'h0000_0001, 32'h0000_0100, 32'hFFFF_FFFF,
                  32'h00B0_00B0, 32'h0000_0002, 32'h0000_0200, 32'hFFFF_FFFF};
        exp_ack = '{8'h01, 8'h02, 8'h04, 8'h08};
        run(14);
        // 0 again after 3
        set_req(0, 1'b0, 32'h00C0_00C0, 32'h0000_0003, 32'h0000_0300);
        exp_q.push_back(32'h00C0_00C0);
        exp_q.push_back(32'h0000_0003);
        exp_q.push_back(32'h0000_0300);
        exp_ack.push_back(8'h01);
        run(5);
        // last is 0 now: 1 before 3
        set_req(3, 1'b1, 32'h0, 32'h0, 32'h0);
        set_req(1, 1'b1, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_ack.push_back(8'h02);
        exp_ack.push_back(8'h08);
        run(5);
        check_streams("rr");

        // backpressure in W_SIZE
        do_reset();
        set_req(0, 1'b0, 32'h0001_0002, 32'h0000_0004, 32'h0000_0400);
        run(2);                       // grant, XY written
        cmd_wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clk_cycle();
            check($sformatf("bp full %0d winc", i), 32'(s_winc), 32'd0);
            check($sformatf("bp full %0d busy", i), 32'(s_busy), 32'd1);
        end
        cmd_wfull = 1'b0;
        clk_cycle();
        check("bp size winc",  32'(s_winc), 32'd1);
        check("bp size wdata", s_wdata,     32'h0000_0004);
        clk_cycle();
        check("bp addr wdata", s_wdata,     32'h0000_0400);
        check("bp addr ack",   32'(s_ack),  32'b0001);
        run(2);
        exp_q = '{32'h0001_0002, 32'h0000_0004, 32'h0000_0400};
        exp_ack = '{8'h01};
        check_streams("bp");

        // illegal XY rejected
        do_reset();
        set_req(2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0500);
        clk_cycle();
        check("rej c0 ack", 32'(s_ack), 32'd0);
        clk_cycle();
        check("rej c1 ack",  32'(s_ack),  32'b0100);
        check("rej c1 err",  32'(s_err),  32'b0100);
        check("rej c1 busy", 32'(s_busy), 32'd0);
        clk_cycle();
        check("rej c2 ack", 32'(s_ack), 32'd0);
        run(2);
        exp_ack = '{8'h44};
        check_streams("rej");

        // init from requester 3
        do_reset();
        set_req(3, 1'b1, 32'h0000_0000, 32'h0, 32'h0);
        clk_cycle();
        check("init c0 busy", 32'(s_busy), 32'd0);
        clk_cycle();
        check("init c1 winc",  32'(s_winc), 32'd1);
        check("init c1 wdata", s_wdata,     32'hFFFF_FFFF);
        check("init c1 ack",   32'(s_ack),  32'b1000);
        check("init c1 err",   32'(s_err),  32'd0);
        check("init c1 busy",  32'(s_busy), 32'd1);
        clk_cycle();
        check("init c2 busy", 32'(s_busy), 32'd0);
        check("init c2 winc", 32'(s_winc), 32'd0);

        // reset mid-draw, then requester 0 wins over 3
        do_reset();
        set_req(2, 1'b0, 32'h0002_0003, 32'h0000_0006, 32'h0000_0600);
        run(2);                       // grant, XY written; now in W_SIZE
        rst_n     = 1'b0;
        req_valid = '0;
        clk_cycle();
        rst_n = 1'b1;
        clk_cycle();
        check("rst busy", 32'(s_busy), 32'd0);
        check("rst winc", 32'(s_winc), 32'd0);
        check("rst ack",  32'(s_ack),  32'd0);
        clear_logs();
        set_req(3, 1'b1, 32'h0, 32'h0, 32'h0);
        set_req(0, 1'b1, 32'h0, 32'h0, 32'h0);
        run(6);
        exp_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp_ack = '{8'h01, 8'h08};
        check_streams("post rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
